// File: rtl/key_matrix_reader.sv
// key_matrix_reader: row-scanned key matrix reader with per-key debounce.
// Define KEY_MATRIX_READER_SYNC_EN to add a 2-flop synchronizer on i_col.
module key_matrix_reader #(
    parameter int ROWS           = 4,
    parameter int COLS           = 2,
    parameter int SCAN_DIV       = 50000,
    parameter int SETTLE         = 16,
    parameter int DEBOUNCE_SCANS = 4,
    localparam int KEYS          = ROWS * COLS,
    localparam int CW            = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic            clk,
    input  logic            i_rst,
    output logic [ROWS-1:0] o_row,
    input  logic [COLS-1:0] i_col,
    output logic [KEYS-1:0] o_keys,
    output logic            o_evt_valid,
    output logic [CW-1:0]   o_evt_code,
    output logic            o_evt_press,
    input  logic            i_evt_ready
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
    localparam logic [DW-1:0]   DW_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DW_SMP   = DW'(SETTLE);
    localparam logic [ROWS-1:0] ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};
    localparam logic [3:0]      DB_TOP   = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0]      DB_SAT   = 4'(DEBOUNCE_SCANS - 1);

    // Scanner state
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_dwell;
    logic [ROWS-1:0] r_row_n;
    logic [RW-1:0]   w_row_nxt;

    // Key state
    logic [KEYS-1:0] r_keys;
    logic [KEYS-1:0] r_pend;
    logic [3:0]      r_cnt [KEYS];

    logic [KEYS-1:0] w_keys_nxt;
    logic [KEYS-1:0] w_pend_set;
    logic [KEYS-1:0] w_pend_clr;
    logic [KEYS-1:0] w_hold;
    logic [3:0]      w_cnt_nxt [KEYS];

    // Emitter state
    logic            r_valid;
    logic [CW-1:0]   r_code;
    logic            r_press;
    logic            w_take;
    logic            w_found;
    logic [CW-1:0]   w_idx;

    // Column path
    logic [COLS-1:0] w_col_raw;
    logic [COLS-1:0] w_col_act;
    logic            w_sample;

`ifdef KEY_MATRIX_READER_SYNC_EN
    logic [COLS-1:0] r_col_s1;
    logic [COLS-1:0] r_col_s2;

    // Two-stage synchronizer; resets to "all keys open"
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
        end else begin
            r_col_s1 <= i_col;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_col_raw = r_col_s2;
`else
    assign w_col_raw = i_col;
`endif

    assign w_col_act = ~w_col_raw;
    assign w_sample  = (r_dwell == DW_SMP);

    assign w_row_nxt = (r_row == ROW_LAST) ? '0 : r_row + RW'(1);

    // Row walker: dwell counter and registered one-cold strobe
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_row   <= '0;
            r_dwell <= '0;
            r_row_n <= ~ROW_ONE;
        end else if (r_dwell == DW_LAST) begin
            r_row   <= w_row_nxt;
            r_dwell <= '0;
            r_row_n <= ~(ROW_ONE << w_row_nxt);
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    // A key is frozen while its event is queued or sitting on the output,
    // so a fast press/release pair cannot overwrite an unaccepted event.
    always_comb begin
        for (int k = 0; k < KEYS; k++) begin
            w_hold[k] = r_pend[k] | (r_valid & (r_code == CW'(k)));
        end
    end

    // Per-key debounce on the driven row at the sample point
    always_comb begin
        w_keys_nxt = r_keys;
        w_pend_set = '0;
        for (int k = 0; k < KEYS; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
        end
        for (int k = 0; k < KEYS; k++) begin
            if (w_sample && (r_row == RW'(k / COLS))) begin
                if (w_col_act[k % COLS] == r_keys[k]) begin
                    w_cnt_nxt[k] = 4'd0;
                end else if (w_hold[k]) begin
                    if (r_cnt[k] >= DB_SAT) begin
                        w_cnt_nxt[k] = DB_SAT;
                    end else begin
                        w_cnt_nxt[k] = r_cnt[k] + 4'd1;
                    end
                end else if (r_cnt[k] + 4'd1 == DB_TOP) begin
                    w_keys_nxt[k] = ~r_keys[k];
                    w_cnt_nxt[k]  = 4'd0;
                    w_pend_set[k] = 1'b1;
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + 4'd1;
                end
            end
        end
    end

    // Lowest-index pending key
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = KEYS - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_found = 1'b1;
                w_idx   = CW'(k);
            end
        end
    end

    assign w_take = ~r_valid | i_evt_ready;

    // Pending bit consumed by the emitter
    always_comb begin
        w_pend_clr = '0;
        if (w_take && w_found) begin
            w_pend_clr[w_idx] = 1'b1;
        end
    end

    // Debounced levels, counters and pending bits (set beats clear)
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_keys <= '0;
            r_pend <= '0;
            for (int k = 0; k < KEYS; k++) begin
                r_cnt[k] <= 4'd0;
            end
        end else begin
            r_keys <= w_keys_nxt;
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
            for (int k = 0; k < KEYS; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    // Event register: reload when empty or being accepted
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_press <= 1'b0;
        end else if (w_take) begin
            r_valid <= w_found;
            if (w_found) begin
                r_code  <= w_idx;
                r_press <= r_keys[w_idx];
            end
        end
    end

    assign o_row       = r_row_n;
    assign o_keys      = r_keys;
    assign o_evt_valid = r_valid;
    assign o_evt_code  = r_code;
    assign o_evt_press = r_press;

endmodule

// File: tb/tb_key_matrix_reader.sv
// tb_key_matrix_reader: random + directed bench with a time-based model.
// Model derives row/sample times from the cycle count since reset.
module tb_key_matrix_reader;

    localparam int ROWS     = 4;
    localparam int COLS     = 2;
    localparam int SCAN_DIV = 8;
    localparam int SETTLE   = 2;
    localparam int DB       = 4;
    localparam int KEYS     = ROWS * COLS;
    localparam int CW       = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [ROWS-1:0] o_row;
    logic [COLS-1:0] i_col;
    logic [KEYS-1:0] o_keys;
    logic            o_evt_valid;
    logic [CW-1:0]   o_evt_code;
    logic            o_evt_press;
    logic            ready;

    logic [KEYS-1:0] phys;
    bit              rnd_ready;

    int total = 0;
    int bad   = 0;

    // Model state
    int              t;
    logic [KEYS-1:0] m_keys;
    logic [KEYS-1:0] m_pend;
    int              m_run [KEYS];
    bit              m_valid;
    int              m_code;
    bit              m_press;
    logic [KEYS-1:0] h1;
    logic [KEYS-1:0] h2;

    always #5 clk = ~clk;

    key_matrix_reader #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .SETTLE(SETTLE), .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk(clk), .i_rst(rst), .o_row(o_row), .i_col(i_col),
        .o_keys(o_keys), .o_evt_valid(o_evt_valid),
        .o_evt_code(o_evt_code), .o_evt_press(o_evt_press),
        .i_evt_ready(ready)
    );

    // Physical matrix: a closed key pulls its column low when its row is driven
    always_comb begin
        i_col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!o_row[r] && phys[r*COLS+c]) i_col[c] = 1'b0;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t       = 0;
        m_keys  = '0;
        m_pend  = '0;
        m_valid = 0;
        m_code  = 0;
        m_press = 0;
        h1      = '0;
        h2      = '0;
        for (int k = 0; k < KEYS; k++) m_run[k] = 0;
    endtask

    // Advance the model across one rising edge given this cycle's inputs
    task automatic model_step();
        logic [KEYS-1:0] nk, set, clr, src;
        int row, idx;
        bit hold;
        if (rst) begin
            model_reset();
            return;
        end
`ifdef KEY_MATRIX_READER_SYNC_EN
        src = h2;
`else
        src = phys;
`endif
        nk  = m_keys;
        set = '0;
        clr = '0;
        row = (t / SCAN_DIV) % ROWS;
        if (t % SCAN_DIV == SETTLE) begin
            for (int c = 0; c < COLS; c++) begin
                int k;
                k = row * COLS + c;
                hold = m_pend[k] || (m_valid && m_code == k);
                if (src[k] == m_keys[k]) m_run[k] = 0;
                else if (hold) m_run[k] = (m_run[k] + 1 > DB - 1) ? DB - 1 : m_run[k] + 1;
                else begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        nk[k] = ~m_keys[k];
                        m_run[k] = 0;
                        set[k] = 1'b1;
                    end
                end
            end
        end
        if (!m_valid || ready) begin
            idx = -1;
            for (int k = KEYS - 1; k >= 0; k--) if (m_pend[k]) idx = k;
            if (idx >= 0) begin
                m_valid = 1;
                m_code  = idx;
                m_press = m_keys[idx];
                clr[idx] = 1'b1;
            end else begin
                m_valid = 0;
            end
        end
        m_pend = (m_pend & ~clr) | set;
        m_keys = nk;
        h2 = h1;
        h1 = phys;
        t++;
    endtask

    // Called at a falling edge: compare, advance model, move to next falling edge
    task automatic step();
        logic [ROWS-1:0] er;
        if (rnd_ready) ready = 1'($urandom_range(0, 1));
        er = '1;
        er[(t / SCAN_DIV) % ROWS] = 1'b0;
        chk("row", 32'(o_row), 32'(er));
        chk("keys", 32'(o_keys), 32'(m_keys));
        chk("valid", 32'(o_evt_valid), 32'(m_valid));
        if (m_valid) begin
            chk("code", 32'(o_evt_code), 32'(m_code));
            chk("press", 32'(o_evt_press), 32'(m_press));
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        phys      = '0;
        ready     = 1'b1;
        rst       = 1'b1;
        rnd_ready = 0;
        repeat (2) @(negedge clk);
        model_reset();
        run(2);
        rst = 1'b0;

        // Idle scan, no keys
        run(80);

        // Key 5 press and release
        phys = 8'h20;
        run(4 * 32 + 40);
        phys = 8'h00;
        run(4 * 32 + 40);

        // Key 0 closed for only two samples
        phys = 8'h01;
        run(64);
        phys = 8'h00;
        run(100);

        // Keys 4 and 5 together with a stalled consumer
        ready = 1'b0;
        phys  = 8'h30;
        run(200);
        ready = 1'b1;
        run(20);
        phys = 8'h00;
        run(200);

        // Key 1 pressed and released while its press is stalled
        ready = 1'b0;
        phys  = 8'h02;
        run(160);
        phys = 8'h00;
        run(200);
        ready = 1'b1;
        run(200);

        // Reset during row 3 with an event outstanding
        ready = 1'b0;
        phys  = 8'h40;
        run(160);
        while (((t / SCAN_DIV) % ROWS) != 3) run(1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("rst_row", 32'(o_row), 32'h0000_000e);
        chk("rst_keys", 32'(o_keys), 32'h0);
        chk("rst_valid", 32'(o_evt_valid), 32'h0);
        phys  = 8'h00;
        ready = 1'b1;
        run(100);

        // Random key activity, random ready, occasional reset
        rnd_ready = 1;
        repeat (60) begin
            phys = phys ^ (8'h01 << $urandom_range(0, KEYS - 1));
            if ($urandom_range(0, 9) == 0) phys = phys ^ 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
            run($urandom_range(5, 180));
        end

        rnd_ready = 0;
        ready     = 1'b1;
        phys      = '0;
        run(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
